ht_ctrl: RTL and testbench

HT_CTRL -- requirements
Module: ht_ctrl

---
 rtl/hash_table_pkg.sv | 38 +++
 rtl/ht_free_sweep.sv | 53 +++++
 rtl/ht_ctrl.sv | 136 +++++++++++++
 tb/tb_ht_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared types for the hash-table controller: bus request, PTE/PTG layout,
// invalid marker and sequencer state encodings.
package hash_table_pkg;

    localparam int ASID_W       = 10;
    localparam int PTES_PER_PTG = 8;
    localparam logic INV        = 1'b0;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [63:0] dat;
    } wb_cmd_request64_t;

    typedef struct packed {
        logic              v;
        logic [ASID_W-1:0] asid;
        logic [52:0]       ppn;
    } pte_t;

    typedef struct packed {
        pte_t [PTES_PER_PTG-1:0] ptge;
    } ptg_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD         = 3'd1,
        ST_RD_WAIT    = 3'd2,
        ST_WR_MERGE   = 3'd3,
        ST_WR         = 3'd4,
        ST_RESP       = 3'd5,
        ST_FREE_MERGE = 3'd6,
        ST_FREE_WR    = 3'd7
    } ht_state_t;

endpackage

// File: rtl/ht_free_sweep.sv
// ASID invalidate sweep bookkeeping: busy flag, latched ASID and the PTE
// counter that walks every slot of every PTG once.
module ht_free_sweep
    import hash_table_pkg::*;
#(
    parameter int CNT_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_free_req,
    input  logic [ASID_W-1:0] i_free_asid,
    input  logic              i_step,
    output logic              o_busy,
    output logic              o_done,
    output logic [ASID_W-1:0] o_asid,
    output logic [CNT_W-1:0]  o_count
);

    logic              r_busy;
    logic              r_done;
    logic [ASID_W-1:0] r_asid;
    logic [CNT_W-1:0]  r_count;

    // NOTE: every register here uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_asid  <= '0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_free_req && !r_busy) begin
                r_busy  <= 1'b1;
                r_asid  <= i_free_asid;
                r_count <= '0;
            end else if (r_busy && i_step) begin
                // Counter wraps to zero naturally on the last slot.
                r_count <= r_count + CNT_W'(1);
                if (&r_count) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_asid  = r_asid;
    assign o_count = r_count;

endmodule

// File: rtl/ht_ctrl.sv
// Hash-table RAM sequencer: serves bus reads/writes of single PTEs as
// read-modify-write of a whole PTG, and interleaves ASID invalidate sweeps.
module ht_ctrl
    import hash_table_pkg::*;
#(
    parameter int PTG_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  wb_cmd_request64_t req,
    output logic              ack,
    output logic [63:0]       dat_o,
    input  logic              free_req,
    input  logic [ASID_W-1:0] free_asid,
    output logic              free_busy,
    output logic              free_done,
    output logic [2:0]        state,
    output wb_cmd_request64_t req_l,
    output logic [ASID_W-1:0] asid_to_free,
    input  ptg_t              douta,
    output logic              ena,
    output logic              wea,
    output logic [PTG_AW-1:0] addra
);

    localparam int CNT_W = PTG_AW + 3;

    ht_state_t         r_state;
    wb_cmd_request64_t r_req_l;
    logic              r_sweep_op;
    logic              r_ack;
    logic [63:0]       r_dat;
    logic              r_ena;
    logic              r_wea;
    logic [PTG_AW-1:0] r_addra;

    logic              w_busy;
    logic [CNT_W-1:0]  w_count;
    logic              w_step;
    wb_cmd_request64_t w_sweep_req;

    assign w_step = (r_state == ST_FREE_WR);

    ht_free_sweep #(
        .CNT_W (CNT_W)
    ) u_free_sweep (
        .clk         (clk),
        .rst         (rst),
        .i_free_req  (free_req),
        .i_free_asid (free_asid),
        .i_step      (w_step),
        .o_busy      (w_busy),
        .o_done      (free_done),
        .o_asid      (asid_to_free),
        .o_count     (w_count)
    );

    // NOTE: default assignment first so no path through this block leaves a latch.
    always_comb begin
        w_sweep_req                   = '0;
        w_sweep_req.adr[PTG_AW+5:3]   = w_count;
    end

    // ena/wea/ack are set on the transition into their state, so they are
    // registered yet high exactly during RD, WR and FREE_WR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req_l    <= '0;
            r_sweep_op <= 1'b0;
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_ena      <= 1'b0;
            r_wea      <= 1'b0;
            r_addra    <= '0;
        end else begin
            r_ack <= 1'b0;
            r_ena <= 1'b0;
            r_wea <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (req.cyc && req.stb) begin
                        r_req_l    <= req;
                        r_addra    <= req.adr[PTG_AW+5:6];
                        r_sweep_op <= 1'b0;
                        r_ena      <= 1'b1;
                        r_state    <= ST_RD;
                    end else if (w_busy) begin
                        r_req_l    <= w_sweep_req;
                        r_addra    <= w_count[CNT_W-1:3];
                        r_sweep_op <= 1'b1;
                        r_ena      <= 1'b1;
                        r_state    <= ST_RD;
                    end
                end
                ST_RD: r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (r_sweep_op) begin
                        r_state <= ST_FREE_MERGE;
                    end else if (r_req_l.we) begin
                        r_state <= ST_WR_MERGE;
                    end else begin
                        r_dat   <= douta.ptge[r_req_l.adr[5:3]];
                        r_ack   <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_WR_MERGE: begin
                    r_ena   <= 1'b1;
                    r_wea   <= 1'b1;
                    r_ack   <= 1'b1;
                    r_state <= ST_WR;
                end
                ST_WR:   r_state <= ST_IDLE;
                ST_RESP: r_state <= ST_IDLE;
                ST_FREE_MERGE: begin
                    r_ena   <= 1'b1;
                    r_wea   <= 1'b1;
                    r_state <= ST_FREE_WR;
                end
                ST_FREE_WR: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign state     = r_state;
    assign req_l     = r_req_l;
    assign ack       = r_ack;
    assign dat_o     = r_dat;
    assign ena       = r_ena;
    assign wea       = r_wea;
    assign addra     = r_addra;
    assign free_busy = w_busy;

endmodule

// File: tb/tb_ht_ctrl.sv
// Directed bench for ht_ctrl: one default-size instance for bus traffic and a
// PTG_AW=2 instance for sweeps, each with its own RAM and merge-stage model.
module tb_ht_ctrl;
    import hash_table_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: PTG_AW = 10
    logic              rst_a;
    wb_cmd_request64_t req_a, reql_a;
    logic              ack_a, busy_a, done_a, ena_a, wea_a, free_req_a;
    logic [63:0]       dat_a;
    logic [9:0]        free_asid_a, asid_a;
    logic [2:0]        state_a;
    logic [9:0]        addra_a;
    ptg_t              douta_a, dina_a;
    ptg_t              mem_a [1024];

    // Instance B: PTG_AW = 2
    logic              rst_b;
    wb_cmd_request64_t req_b, reql_b;
    logic              ack_b, busy_b, done_b, ena_b, wea_b, free_req_b;
    logic [63:0]       dat_b;
    logic [9:0]        free_asid_b, asid_b;
    logic [2:0]        state_b;
    logic [1:0]        addra_b;
    ptg_t              douta_b, dina_b;
    ptg_t              mem_b [4];

    ht_ctrl u_dut_a (
        .clk (clk), .rst (rst_a), .req (req_a), .ack (ack_a), .dat_o (dat_a),
        .free_req (free_req_a), .free_asid (free_asid_a), .free_busy (busy_a),
        .free_done (done_a), .state (state_a), .req_l (reql_a),
        .asid_to_free (asid_a), .douta (douta_a), .ena (ena_a), .wea (wea_a),
        .addra (addra_a)
    );

    ht_ctrl #(.PTG_AW(2)) u_dut_b (
        .clk (clk), .rst (rst_b), .req (req_b), .ack (ack_b), .dat_o (dat_b),
        .free_req (free_req_b), .free_asid (free_asid_b), .free_busy (busy_b),
        .free_done (done_b), .state (state_b), .req_l (reql_b),
        .asid_to_free (asid_b), .douta (douta_b), .ena (ena_b), .wea (wea_b),
        .addra (addra_b)
    );

    function automatic pte_t init_pte(int g, int s);
        pte_t p;
        p.v    = 1'b1;
        p.asid = 10'h100;
        if (g == 2 && s == 3) p.asid = 10'd5;
        if (g == 3 && s == 6) p.asid = 10'd3;
        p.ppn  = 53'(g * 8 + s);
        return p;
    endfunction

    function automatic ptg_t init_ptg(int g);
        ptg_t t;
        for (int s = 0; s < 8; s++) t.ptge[s] = init_pte(g, s);
        return t;
    endfunction

    function automatic ptg_t merge_wr(ptg_t d, wb_cmd_request64_t r);
        ptg_t m = d;
        m.ptge[r.adr[5:3]] = r.dat;
        return m;
    endfunction

    function automatic ptg_t merge_free(ptg_t d, wb_cmd_request64_t r, logic [9:0] asid);
        ptg_t m = d;
        if (m.ptge[r.adr[5:3]].asid == asid) m.ptge[r.adr[5:3]].v = INV;
        return m;
    endfunction

    // RAM with one-cycle registered read, plus the external merge stage
    always @(posedge clk) begin
        if (rst_a) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= init_ptg(i);
        end else if (ena_a) begin
            if (wea_a) mem_a[addra_a] <= dina_a;
            else       douta_a <= mem_a[addra_a];
        end
        if (state_a == 3'd3) dina_a <= merge_wr(douta_a, reql_a);
        if (state_a == 3'd6) dina_a <= merge_free(douta_a, reql_a, asid_a);
    end

    always @(posedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < 4; i++) mem_b[i] <= init_ptg(i);
        end else if (ena_b) begin
            if (wea_b) mem_b[addra_b] <= dina_b;
            else       douta_b <= mem_b[addra_b];
        end
        if (state_b == 3'd3) dina_b <= merge_wr(douta_b, reql_b);
        if (state_b == 3'd6) dina_b <= merge_free(douta_b, reql_b, asid_b);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bus request at a negedge and hold it until ack (bounded)
    task automatic bus_op(input bit sel, input logic [31:0] adr, input logic [63:0] dat,
                          input bit we, output int lat, output logic [63:0] rdat,
                          output int wcnt, output int adr_seen, output bit ena1);
        wb_cmd_request64_t r;
        r     = '0;
        r.cyc = 1'b1;
        r.stb = 1'b1;
        r.we  = we;
        r.adr = adr;
        r.dat = dat;
        if (sel) req_b = r; else req_a = r;
        lat = -1; rdat = '0; wcnt = 0; adr_seen = -1; ena1 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                adr_seen = sel ? int'(addra_b) : int'(addra_a);
                ena1     = sel ? ena_b : ena_a;
            end
            if (sel ? wea_b : wea_a) wcnt++;
            if (sel ? ack_b : ack_a) begin
                lat  = k;
                rdat = sel ? dat_b : dat_a;
                break;
            end
        end
        if (sel) req_b = '0; else req_a = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat, wcnt, adr_seen, frw, dn, n_ack, n_wea, n_rd, idx1, idx2, n_inv, idx;
        logic [63:0] rdat;
        logic [9:0]  asid_mid;
        bit ena1, restarted, hit, we_seen;

        rst_a = 1'b1; rst_b = 1'b1;
        req_a = '0; req_b = '0;
        free_req_a = 1'b0; free_req_b = 1'b0;
        free_asid_a = '0; free_asid_b = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("a_state_rst", 64'(state_a), 64'(0));
        check("a_ack_rst",   64'(ack_a),   64'(0));
        check("a_dat_rst",   dat_a,        64'(0));
        check("a_ena_rst",   64'(ena_a),   64'(0));
        check("a_wea_rst",   64'(wea_a),   64'(0));
        check("a_addra_rst", 64'(addra_a), 64'(0));
        check("a_reql_rst",  64'(|reql_a), 64'(0));
        check("a_busy_rst",  64'(busy_a),  64'(0));
        check("a_done_rst",  64'(done_a),  64'(0));
        check("a_asid_rst",  64'(asid_a),  64'(0));
        check("b_state_rst", 64'(state_b), 64'(0));
        check("b_busy_rst",  64'(busy_b),  64'(0));
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Write 0xDEAD_BEEF to PTG 7 slot 1
        bus_op(1'b0, 32'h1C8, 64'hDEAD_BEEF, 1'b1, lat, rdat, wcnt, adr_seen, ena1);
        check("wr_latency", 64'(lat),      64'(4));
        check("wr_addra",   64'(adr_seen), 64'(7));
        check("wr_rd_ena",  64'(ena1),     64'(1));
        check("wr_wea_cnt", 64'(wcnt),     64'(1));
        @(negedge clk);
        check("wr_ack_drop",   64'(ack_a),             64'(0));
        check("wr_state_idle", 64'(state_a),           64'(0));
        check("wr_mem_slot1",  64'(mem_a[7].ptge[1]),  64'hDEAD_BEEF);
        check("wr_mem_slot0",  64'(mem_a[7].ptge[0]),  64'(init_pte(7, 0)));

        // Read it back, then via an alias with high address bits set
        bus_op(1'b0, 32'h1C8, 64'h0, 1'b0, lat, rdat, wcnt, adr_seen, ena1);
        check("rd_latency", 64'(lat),  64'(3));
        check("rd_data",    rdat,      64'hDEAD_BEEF);
        check("rd_no_wea",  64'(wcnt), 64'(0));
        @(negedge clk);
        bus_op(1'b0, 32'h0010_01C8, 64'h0, 1'b0, lat, rdat, wcnt, adr_seen, ena1);
        check("rd_hi_addra", 64'(adr_seen), 64'(7));
        check("rd_hi_data",  rdat,          64'hDEAD_BEEF);
        @(negedge clk);
        bus_op(1'b0, 32'h1C0, 64'h0, 1'b0, lat, rdat, wcnt, adr_seen, ena1);
        check("rd_slot0", rdat, 64'(init_pte(7, 0)));
        @(negedge clk);

        // Reset while in WR_MERGE
        req_a     = '0;
        req_a.cyc = 1'b1; req_a.stb = 1'b1; req_a.we = 1'b1;
        req_a.adr = 32'h100; req_a.dat = 64'h1234;
        hit = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (state_a == 3'd3) begin hit = 1'b1; break; end
        end
        check("rst_reach_merge", 64'(hit), 64'(1));
        rst_a = 1'b1; req_a = '0;
        @(negedge clk);
        check("rst_state", 64'(state_a), 64'(0));
        check("rst_wea",   64'(wea_a),   64'(0));
        check("rst_ack",   64'(ack_a),   64'(0));
        rst_a = 1'b0;
        n_ack = 0; n_wea = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_a) n_ack++;
            if (wea_a) n_wea++;
        end
        check("rst_no_late_ack", 64'(n_ack), 64'(0));
        check("rst_no_late_wea", 64'(n_wea), 64'(0));

        // Full sweep of ASID 5 on PTG_AW=2, with an ignored restart after 4 slots
        free_asid_b = 10'd5; free_req_b = 1'b1;
        @(negedge clk);
        free_req_b = 1'b0;
        check("sw_busy", 64'(busy_b), 64'(1));
        check("sw_asid", 64'(asid_b), 64'(5));
        frw = 0; dn = 0; n_ack = 0; n_wea = 0; n_rd = 0;
        idx1 = -1; idx2 = -1; restarted = 1'b0; asid_mid = '0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            free_req_b = 1'b0;
            if (state_b == 3'd7) frw++;
            if (wea_b) n_wea++;
            if (ack_b) n_ack++;
            if (done_b) dn++;
            if (restarted && state_b == 3'd1) begin
                n_rd++;
                if (n_rd == 1) idx1 = int'(reql_b.adr[7:3]);
                if (n_rd == 2) begin
                    idx2     = int'(reql_b.adr[7:3]);
                    asid_mid = asid_b;
                end
            end
            if (!restarted && frw == 4 && state_b == 3'd0) begin
                free_asid_b = 10'd3;
                free_req_b  = 1'b1;
                restarted   = 1'b1;
            end
            if (dn > 0 && !busy_b) break;
        end
        check("sw_free_wr_cnt", 64'(frw),      64'(32));
        check("sw_wea_cnt",     64'(n_wea),    64'(32));
        check("sw_no_ack",      64'(n_ack),    64'(0));
        check("sw_busy_end",    64'(busy_b),   64'(0));
        check("sw_restart_idx1", 64'(idx1),    64'(4));
        check("sw_restart_idx2", 64'(idx2),    64'(5));
        check("sw_restart_asid", 64'(asid_mid), 64'(5));
        repeat (10) begin
            @(negedge clk);
            if (done_b) dn++;
        end
        check("sw_done_once", 64'(dn), 64'(1));
        n_inv = 0;
        for (int g = 0; g < 4; g++)
            for (int s = 0; s < 8; s++)
                if (mem_b[g].ptge[s].v == INV) n_inv++;
        check("sw_inv_count",  64'(n_inv),                  64'(1));
        check("sw_target_inv", 64'(mem_b[2].ptge[3].v),     64'(INV));
        check("sw_decoy_vld",  64'(mem_b[3].ptge[6].v),     64'(1));
        check("sw_target_ppn", 64'(mem_b[2].ptge[3].ppn),   64'(19));

        // Bus read collides with the sweep iteration due at counter 9
        free_asid_b = 10'h3FF; free_req_b = 1'b1;
        @(negedge clk);
        free_req_b = 1'b0;
        frw = 0; hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (state_b == 3'd7) frw++;
            if (frw == 9 && state_b == 3'd0) begin hit = 1'b1; break; end
        end
        check("col_reach", 64'(hit), 64'(1));
        bus_op(1'b1, 32'h0C0, 64'h0, 1'b0, lat, rdat, wcnt, adr_seen, ena1);
        check("col_latency", 64'(lat),      64'(3));
        check("col_addra",   64'(adr_seen), 64'(3));
        check("col_data",    rdat,          64'(init_pte(3, 0)));
        idx = -1; we_seen = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (state_b == 3'd1) begin
                idx     = int'(reql_b.adr[7:3]);
                we_seen = reql_b.we;
                break;
            end
        end
        check("col_resume_idx", 64'(idx),     64'(9));
        check("col_resume_we",  64'(we_seen), 64'(0));

        // Reset mid-sweep aborts without free_done
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("swrst_busy",  64'(busy_b),  64'(0));
        check("swrst_state", 64'(state_b), 64'(0));
        dn = 0; frw = 0;
        repeat (200) begin
            @(negedge clk);
            if (done_b) dn++;
            if (state_b == 3'd7) frw++;
        end
        check("swrst_no_done", 64'(dn),  64'(0));
        check("swrst_idle",    64'(frw), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
